noc_credit_pipeline_link: RTL and testbench
===========================================

Name: noc_credit_pipeline_link

Overview:
Parametrised router-to-router link with credit return and protocol checking. It sits between a router output port and the neighbouring router input port, or between the injection/ejection shims and the router.
- Adds NUM_PIPELINE register stages to the forward flit path and to the reverse credit path.
- Keeps a shadow credit counter of free downstream buffer slots.
- Checks credit and packet protocol and raises sticky error flags.
- With NUM_PIPELINE=0 it degenerates to wires plus the checkers.

Parameters:
FLIT_WIDTH, 128, flit payload width
DEST_WIDTH, 6, destination field width (TDEST+TID)
NUM_PIPELINE, 2, register stages per direction, legal 0..8
FLIT_BUFFER_DEPTH, 2, downstream input-buffer depth; initial credit count, legal 1..64
CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width
STAT_WIDTH, 32, statistics counter width

Ports:
clk_noc  in  1  NoC clock
rst_n  in  1  asynchronous active-low reset
data_in  in  FLIT_WIDTH  flit from upstream sender
dest_in  in  DEST_WIDTH  destination from upstream sender
is_tail_in  in  1  last flit of packet
send_in  in  1  flit valid, one flit per asserted cycle
credit_out  out  1  credit returned to upstream sender
data_out  out  FLIT_WIDTH  flit to downstream receiver
dest_out  out  DEST_WIDTH  destination to downstream receiver
is_tail_out  out  1  tail flag to downstream receiver
send_out  out  1  flit valid to downstream receiver
credit_in  in  1  credit from downstream receiver
credit_count  out  CREDIT_WIDTH  shadow count of credits held by the upstream sender
in_packet  out  1  a head has been accepted and its tail has not yet been seen
err_credit_underflow  out  1  sticky: send_in while credit_count==0
err_credit_overflow  out  1  sticky: credit would raise count above FLIT_BUFFER_DEPTH
err_dest_change  out  1  sticky: dest_in differs from the head's dest mid-packet
flit_count  out  STAT_WIDTH  flits forwarded (LINK_STATS_EN only)
pkt_count  out  STAT_WIDTH  tails forwarded (LINK_STATS_EN only)

Behaviour:
- Clock and reset: single clock clk_noc; rst_n is asynchronous assert, synchronous deassert (deassertion is synchronised externally).
- Reset values:
  - All send and credit pipeline valid bits = 0; data, dest and tail stages = 0.
  - send_out = 0, credit_out = 0, data_out = 0, dest_out = 0, is_tail_out = 0.
  - credit_count = FLIT_BUFFER_DEPTH.
  - in_packet = 0; all err_* = 0; flit_count = 0, pkt_count = 0.
- Forward path: {send, is_tail, dest, data} sampled at cycle t appears on the outputs at t+NUM_PIPELINE. Data, dest and tail stages capture every cycle; only send carries meaning.
- Reverse path: credit_in at cycle t appears on credit_out at t+NUM_PIPELINE.
- NUM_PIPELINE=0: outputs combinationally equal inputs; the checkers are still registered.
- Shadow counter (updated at the link input side):
  - send_in only: decrement.
  - credit_out only: increment.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Underflow: send_in with count==0 and no credit_out that cycle sets err_credit_underflow. Count holds at 0 and the flit is still forwarded.
- Overflow: credit_out with count==FLIT_BUFFER_DEPTH and no send_in that cycle sets err_credit_overflow. Count holds at max.
- Packet FSM, states IDLE and BODY, reflected on in_packet (BODY=1):
  - IDLE, send_in with is_tail_in=0: latch dest_in, go to BODY.
  - IDLE, send_in with is_tail_in=1: single-flit packet, stay IDLE.
  - BODY, send_in with dest_in != latched dest: set err_dest_change.
  - BODY, send_in with is_tail_in=1: go to IDLE.
  - Cycles without send_in: state unchanged.
- Error flags: sticky until reset; they never block traffic.
- Reset mid-packet: all pipeline contents are discarded immediately, with no partial flush; FSM returns to IDLE and the count reloads to FLIT_BUFFER_DEPTH.

Optional Feature:
Macro NOC_LINK_STATS_EN.
- Defined:
  - flit_count increments on each send_out.
  - pkt_count increments on each send_out with is_tail_out=1.
  - Both saturate at all-ones; both reset to 0.
- Undefined: the counters are not instantiated and flit_count/pkt_count are tied to 0. Ports are present in both builds.

Test Plan:
- NUM_PIPELINE=2, DEPTH=2. Reset, then a single send_in at cycle 5 with data=0xA5, dest=0x09, tail=1 -> send_out=1 at cycle 7 with the same fields; credit_count goes 2->1 at cycle 6.
- DEPTH=2. Three back-to-back sends with no credits -> third send sets err_credit_underflow=1 and count stays 0; the flit still appears on send_out.
- send_in and credit_out in the same cycle with count=1 -> count remains 1 and no error flags set.
- 4-flit packet with dest=0x05, third flit dest=0x06 -> err_dest_change=1; in_packet=1 from the cycle after the head until the cycle after the tail.
- NUM_PIPELINE=0 -> send_out/data_out equal inputs in the same cycle. credit_in pulsed at count==DEPTH -> err_credit_overflow=1.
- rst_n asserted while 2 flits are in the pipe -> send_out=0 immediately, no flits emerge after release, count=DEPTH. With NOC_LINK_STATS_EN: a 3-packet, 7-flit run gives flit_count=7, pkt_count=3.

Source files
------------

// File: rtl/noc_credit_pipeline_link_if.sv
// ---------------------------------------------------------------------------
// noc_credit_pipeline_link_if
// One direction of a credit-based NoC link: a flit channel flowing from the
// sender to the receiver plus a single-bit credit flowing back.
//
// Signals:
//   data     flit payload               (sender -> receiver)
//   dest     destination field          (sender -> receiver)
//   is_tail  last flit of the packet    (sender -> receiver)
//   send     flit valid, one per cycle  (sender -> receiver)
//   credit   buffer slot freed          (receiver -> sender)
//
// Modports:
//   master   the sending side (drives the flit, consumes the credit)
//   slave    the receiving side (consumes the flit, returns the credit)
// ---------------------------------------------------------------------------
interface noc_credit_pipeline_link_if #(
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 6
);
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
    logic                  credit;

    modport master (output data, dest, is_tail, send, input credit);
    modport slave  (input data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_credit_pipeline_link.sv
// ---------------------------------------------------------------------------
// noc_credit_pipeline_link
// Router-to-router link that retimes the forward flit path and the reverse
// credit path by NUM_PIPELINE register stages each, keeps a shadow count of
// the credits held by the upstream sender, and watches the credit and packet
// protocol with sticky error flags. With NUM_PIPELINE=0 both paths are
// wires; the checkers remain registered.
//
// Optional build macro: NOC_LINK_STATS_EN
//   defined   -> saturating flit/tail counters at the link output
//   undefined -> flit_count and pkt_count are tied to zero
//
// Ports:
//   clk_noc               NoC clock
//   rst_n                 asynchronous active-low reset
//   up_if (slave)         flit in from the upstream sender; credit_out back
//   dn_if (master)        flit out to the downstream receiver; credit_in back
//   credit_count          shadow count of credits held by the upstream sender
//   in_packet             a head has been accepted, its tail not yet seen
//   err_credit_underflow  sticky: flit sent while no credit was held
//   err_credit_overflow   sticky: credit returned while count was at maximum
//   err_dest_change       sticky: destination changed inside a packet
//   flit_count            flits forwarded (stats build only)
//   pkt_count             tails forwarded (stats build only)
// ---------------------------------------------------------------------------
module noc_credit_pipeline_link #(
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int STAT_WIDTH        = 32
) (
    input  logic                          clk_noc,
    input  logic                          rst_n,
    noc_credit_pipeline_link_if.slave     up_if,
    noc_credit_pipeline_link_if.master    dn_if,
    output logic [CREDIT_WIDTH-1:0]       credit_count,
    output logic                          in_packet,
    output logic                          err_credit_underflow,
    output logic                          err_credit_overflow,
    output logic                          err_dest_change,
    output logic [STAT_WIDTH-1:0]         flit_count,
    output logic [STAT_WIDTH-1:0]         pkt_count
);

    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDIT = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] ONE_CREDIT = CREDIT_WIDTH'(1);

    typedef enum logic [0:0] {
        PKT_IDLE = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_t;

    // -----------------------------------------------------------------------
    // Forward and reverse retiming
    // -----------------------------------------------------------------------
    generate
        if (NUM_PIPELINE == 0) begin : g_wire
            assign dn_if.data    = up_if.data;
            assign dn_if.dest    = up_if.dest;
            assign dn_if.is_tail = up_if.is_tail;
            assign dn_if.send    = up_if.send;
            assign up_if.credit  = dn_if.credit;
        end else begin : g_pipe
            logic [FLIT_WIDTH-1:0]   data_pipe_r [NUM_PIPELINE];
            logic [DEST_WIDTH-1:0]   dest_pipe_r [NUM_PIPELINE];
            logic [NUM_PIPELINE-1:0] tail_pipe_r;
            logic [NUM_PIPELINE-1:0] send_pipe_r;
            logic [NUM_PIPELINE-1:0] credit_pipe_r;

            // Shift flit fields downstream and the credit upstream, one stage per cycle
            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NUM_PIPELINE; i++) begin
                        data_pipe_r[i] <= '0;
                        dest_pipe_r[i] <= '0;
                    end
                    tail_pipe_r   <= '0;
                    send_pipe_r   <= '0;
                    credit_pipe_r <= '0;
                end else begin
                    data_pipe_r[0]   <= up_if.data;
                    dest_pipe_r[0]   <= up_if.dest;
                    tail_pipe_r[0]   <= up_if.is_tail;
                    send_pipe_r[0]   <= up_if.send;
                    credit_pipe_r[0] <= dn_if.credit;
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        data_pipe_r[i]   <= data_pipe_r[i-1];
                        dest_pipe_r[i]   <= dest_pipe_r[i-1];
                        tail_pipe_r[i]   <= tail_pipe_r[i-1];
                        send_pipe_r[i]   <= send_pipe_r[i-1];
                        credit_pipe_r[i] <= credit_pipe_r[i-1];
                    end
                end
            end

            assign dn_if.data    = data_pipe_r[NUM_PIPELINE-1];
            assign dn_if.dest    = dest_pipe_r[NUM_PIPELINE-1];
            assign dn_if.is_tail = tail_pipe_r[NUM_PIPELINE-1];
            assign dn_if.send    = send_pipe_r[NUM_PIPELINE-1];
            assign up_if.credit  = credit_pipe_r[NUM_PIPELINE-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Shadow credit counter, observed at the upstream side of the link:
    // a flit consumes a credit, a returned credit (credit_out) restores one.
    // -----------------------------------------------------------------------
    logic [CREDIT_WIDTH-1:0] credit_count_r;
    logic [CREDIT_WIDTH-1:0] credit_next_s;
    logic                    underflow_s;
    logic                    overflow_s;
    logic                    err_underflow_r;
    logic                    err_overflow_r;

    // Next credit count; out-of-range events hold the count and flag an error
    always_comb begin
        credit_next_s = credit_count_r;
        underflow_s   = 1'b0;
        overflow_s    = 1'b0;
        if (up_if.send && !up_if.credit) begin
            if (credit_count_r == {CREDIT_WIDTH{1'b0}}) begin
                underflow_s = 1'b1;
            end else begin
                credit_next_s = credit_count_r - ONE_CREDIT;
            end
        end else if (up_if.credit && !up_if.send) begin
            if (credit_count_r == MAX_CREDIT) begin
                overflow_s = 1'b1;
            end else begin
                credit_next_s = credit_count_r + ONE_CREDIT;
            end
        end else begin
            credit_next_s = credit_count_r;
        end
    end

    // Credit count register and sticky credit-protocol flags
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_count_r  <= MAX_CREDIT;
            err_underflow_r <= 1'b0;
            err_overflow_r  <= 1'b0;
        end else begin
            credit_count_r  <= credit_next_s;
            err_underflow_r <= err_underflow_r | underflow_s;
            err_overflow_r  <= err_overflow_r | overflow_s;
        end
    end

    // -----------------------------------------------------------------------
    // Packet framing checker
    // -----------------------------------------------------------------------
    pkt_state_t              pkt_state_r;
    logic [DEST_WIDTH-1:0]   head_dest_r;
    logic                    in_packet_r;
    logic                    err_dest_change_r;

    // Track head/tail framing and compare body destinations against the head
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state_r       <= PKT_IDLE;
            head_dest_r       <= '0;
            in_packet_r       <= 1'b0;
            err_dest_change_r <= 1'b0;
        end else begin
            case (pkt_state_r)
                PKT_IDLE: begin
                    // A head that is also a tail is a single-flit packet
                    if (up_if.send && !up_if.is_tail) begin
                        pkt_state_r <= PKT_BODY;
                        head_dest_r <= up_if.dest;
                        in_packet_r <= 1'b1;
                    end
                end
                PKT_BODY: begin
                    if (up_if.send) begin
                        if (up_if.dest != head_dest_r) begin
                            err_dest_change_r <= 1'b1;
                        end
                        if (up_if.is_tail) begin
                            pkt_state_r <= PKT_IDLE;
                            in_packet_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    pkt_state_r <= PKT_IDLE;
                    in_packet_r <= 1'b0;
                end
            endcase
        end
    end

    assign credit_count         = credit_count_r;
    assign in_packet            = in_packet_r;
    assign err_credit_underflow = err_underflow_r;
    assign err_credit_overflow  = err_overflow_r;
    assign err_dest_change      = err_dest_change_r;

    // -----------------------------------------------------------------------
    // Output-side statistics
    // -----------------------------------------------------------------------
`ifdef NOC_LINK_STATS_EN
    logic [STAT_WIDTH-1:0] flit_count_r;
    logic [STAT_WIDTH-1:0] pkt_count_r;

    // Count flits and tails leaving the link, saturating at all-ones
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            flit_count_r <= '0;
            pkt_count_r  <= '0;
        end else begin
            if (dn_if.send && (flit_count_r != '1)) begin
                flit_count_r <= flit_count_r + STAT_WIDTH'(1);
            end
            if (dn_if.send && dn_if.is_tail && (pkt_count_r != '1)) begin
                pkt_count_r <= pkt_count_r + STAT_WIDTH'(1);
            end
        end
    end

    assign flit_count = flit_count_r;
    assign pkt_count  = pkt_count_r;
`else
    assign flit_count = '0;
    assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_noc_credit_pipeline_link.sv
// ---------------------------------------------------------------------------
// tb_noc_credit_pipeline_link
// Drives a 2-stage link and a 0-stage link with identical stimulus. A
// behavioural model derives every expected output from cycle-indexed input
// history (output at cycle n = input at cycle n-latency since reset) and the
// credit/packet rules, and is compared on every negative clock edge. Directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noc_credit_pipeline_link;

    localparam int FW    = 128;
    localparam int DW    = 6;
    localparam int DEPTH = 2;
    localparam int CW    = 2;
    localparam int SW    = 32;
    localparam int HN    = 16;

    typedef struct packed {
        logic          send;
        logic          tail;
        logic [DW-1:0] dest;
        logic [FW-1:0] data;
        logic          credit;
    } rec_t;

    logic          clk_noc   = 1'b0;
    logic          rst_n     = 1'b0;
    logic [FW-1:0] st_data   = '0;
    logic [DW-1:0] st_dest   = '0;
    logic          st_tail   = 1'b0;
    logic          st_send   = 1'b0;
    logic          st_credit = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk_noc = ~clk_noc;

    noc_credit_pipeline_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up_a ();
    noc_credit_pipeline_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) dn_a ();
    noc_credit_pipeline_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up_b ();
    noc_credit_pipeline_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) dn_b ();

    assign up_a.data    = st_data;
    assign up_a.dest    = st_dest;
    assign up_a.is_tail = st_tail;
    assign up_a.send    = st_send;
    assign dn_a.credit  = st_credit;
    assign up_b.data    = st_data;
    assign up_b.dest    = st_dest;
    assign up_b.is_tail = st_tail;
    assign up_b.send    = st_send;
    assign dn_b.credit  = st_credit;

    logic [FW-1:0] o_data   [2];
    logic [DW-1:0] o_dest   [2];
    logic          o_tail   [2];
    logic          o_send   [2];
    logic          o_credit [2];
    logic [CW-1:0] o_cnt    [2];
    logic          o_inpk   [2];
    logic          o_uf     [2];
    logic          o_of     [2];
    logic          o_dc     [2];
    logic [SW-1:0] o_fc     [2];
    logic [SW-1:0] o_pc     [2];

    assign o_data[0]   = dn_a.data;
    assign o_dest[0]   = dn_a.dest;
    assign o_tail[0]   = dn_a.is_tail;
    assign o_send[0]   = dn_a.send;
    assign o_credit[0] = up_a.credit;
    assign o_data[1]   = dn_b.data;
    assign o_dest[1]   = dn_b.dest;
    assign o_tail[1]   = dn_b.is_tail;
    assign o_send[1]   = dn_b.send;
    assign o_credit[1] = up_b.credit;

    noc_credit_pipeline_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(2),
        .FLIT_BUFFER_DEPTH(DEPTH), .CREDIT_WIDTH(CW), .STAT_WIDTH(SW)
    ) dut_a (
        .clk_noc(clk_noc), .rst_n(rst_n), .up_if(up_a), .dn_if(dn_a),
        .credit_count(o_cnt[0]), .in_packet(o_inpk[0]),
        .err_credit_underflow(o_uf[0]), .err_credit_overflow(o_of[0]),
        .err_dest_change(o_dc[0]), .flit_count(o_fc[0]), .pkt_count(o_pc[0])
    );

    noc_credit_pipeline_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0),
        .FLIT_BUFFER_DEPTH(DEPTH), .CREDIT_WIDTH(CW), .STAT_WIDTH(SW)
    ) dut_b (
        .clk_noc(clk_noc), .rst_n(rst_n), .up_if(up_b), .dn_if(dn_b),
        .credit_count(o_cnt[1]), .in_packet(o_inpk[1]),
        .err_credit_underflow(o_uf[1]), .err_credit_overflow(o_of[1]),
        .err_dest_change(o_dc[1]), .flit_count(o_fc[1]), .pkt_count(o_pc[1])
    );

    task automatic chk(input string name, input int d, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    rec_t          hist  [2][HN];
    int            n_m   [2];
    int            cnt_m [2];
    bit            uf_m  [2];
    bit            of_m  [2];
    bit            dc_m  [2];
    bit            pk_m  [2];
    logic [DW-1:0] hd_m  [2];
    logic [SW-1:0] fc_m  [2];
    logic [SW-1:0] pc_m  [2];

    task automatic model_and_compare(input int d);
        rec_t          cur;
        rec_t          req;
        int            lat;
        logic [SW-1:0] fc_req;
        logic [SW-1:0] pc_req;
        lat = (d == 0) ? 2 : 0;
        cur = {st_send, st_tail, st_dest, st_data, st_credit};
        if (!rst_n) begin
            n_m[d] = 0; cnt_m[d] = DEPTH;
            uf_m[d] = 1'b0; of_m[d] = 1'b0; dc_m[d] = 1'b0; pk_m[d] = 1'b0;
            fc_m[d] = '0; pc_m[d] = '0;
            req = (lat == 0) ? cur : '0;
        end else begin
            hist[d][n_m[d] % HN] = cur;
            req = (n_m[d] >= lat) ? hist[d][(n_m[d] - lat) % HN] : '0;
        end
`ifdef NOC_LINK_STATS_EN
        fc_req = fc_m[d];
        pc_req = pc_m[d];
`else
        fc_req = '0;
        pc_req = '0;
`endif
        chk("send_out",     d, FW'(o_send[d]),   FW'(req.send));
        chk("data_out",     d, o_data[d],        req.data);
        chk("dest_out",     d, FW'(o_dest[d]),   FW'(req.dest));
        chk("is_tail_out",  d, FW'(o_tail[d]),   FW'(req.tail));
        chk("credit_out",   d, FW'(o_credit[d]), FW'(req.credit));
        chk("credit_count", d, FW'(o_cnt[d]),    FW'(cnt_m[d]));
        chk("in_packet",    d, FW'(o_inpk[d]),   FW'(pk_m[d]));
        chk("err_underflow",d, FW'(o_uf[d]),     FW'(uf_m[d]));
        chk("err_overflow", d, FW'(o_of[d]),     FW'(of_m[d]));
        chk("err_dest",     d, FW'(o_dc[d]),     FW'(dc_m[d]));
        chk("flit_count",   d, FW'(o_fc[d]),     FW'(fc_req));
        chk("pkt_count",    d, FW'(o_pc[d]),     FW'(pc_req));
        if (rst_n) begin
            if (cur.send && !req.credit) begin
                if (cnt_m[d] == 0) uf_m[d] = 1'b1;
                else cnt_m[d] = cnt_m[d] - 1;
            end else if (req.credit && !cur.send) begin
                if (cnt_m[d] == DEPTH) of_m[d] = 1'b1;
                else cnt_m[d] = cnt_m[d] + 1;
            end
            if (cur.send) begin
                if (!pk_m[d]) begin
                    if (!cur.tail) begin
                        pk_m[d] = 1'b1;
                        hd_m[d] = cur.dest;
                    end
                end else begin
                    if (cur.dest != hd_m[d]) dc_m[d] = 1'b1;
                    if (cur.tail) pk_m[d] = 1'b0;
                end
            end
            if (req.send && fc_m[d] != '1) fc_m[d] = fc_m[d] + 1;
            if (req.send && req.tail && pc_m[d] != '1) pc_m[d] = pc_m[d] + 1;
            n_m[d] = n_m[d] + 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_noc);
            model_and_compare(0);
            model_and_compare(1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: drive just after the rising edge, look at falling
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic look();
        @(negedge clk_noc);
    endtask

    task automatic drive(input logic s, input logic t, input logic [DW-1:0] de,
                         input logic [FW-1:0] da, input logic c);
        st_send = s; st_tail = t; st_dest = de; st_data = da; st_credit = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'h00, 128'h0, 1'b0);
    endtask

    // Leaves the bench in cycle 0 of a fresh reset epoch
    task automatic reset_link();
        step();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    int ps;
    int pcr;
    int plen [3] = '{3, 2, 2};

    initial begin
        // Directed: single flit latency and first decrement
        reset_link();
        look();
        chk("rst_count", 0, FW'(o_cnt[0]), 128'd2);
        chk("rst_send",  0, FW'(o_send[0]), 128'd0);
        chk("rst_inpkt", 0, FW'(o_inpk[0]), 128'd0);
        step(); drive(1'b1, 1'b1, 6'h09, 128'hA5, 1'b0);
        look();
        chk("p0_send_same_cycle", 1, FW'(o_send[1]), 128'd1);
        chk("p0_data_same_cycle", 1, o_data[1], 128'hA5);
        chk("count_before_edge",  0, FW'(o_cnt[0]), 128'd2);
        step(); idle();
        look();
        chk("count_after_send",   0, FW'(o_cnt[0]), 128'd1);
        chk("p2_not_yet_out",     0, FW'(o_send[0]), 128'd0);
        step();
        look();
        chk("p2_send_out",  0, FW'(o_send[0]), 128'd1);
        chk("p2_data_out",  0, o_data[0], 128'hA5);
        chk("p2_dest_out",  0, FW'(o_dest[0]), 128'h09);
        chk("p2_tail_out",  0, FW'(o_tail[0]), 128'd1);
        step();
        look();
        chk("p2_send_done", 0, FW'(o_send[0]), 128'd0);

        // Directed: three sends with no credits
        reset_link();
        for (int i = 1; i <= 3; i++) begin
            step(); drive(1'b1, 1'b1, 6'h01, FW'(i), 1'b0);
        end
        look();
        chk("uf_not_yet", 0, FW'(o_uf[0]), 128'd0);
        step(); idle();
        look();
        chk("uf_set",     0, FW'(o_uf[0]), 128'd1);
        chk("uf_count0",  0, FW'(o_cnt[0]), 128'd0);
        step();
        look();
        chk("uf_flit_fwd",  0, FW'(o_send[0]), 128'd1);
        chk("uf_flit_data", 0, o_data[0], 128'd3);

        // Directed: send and returned credit in the same cycle at count 1
        reset_link();
        step(); drive(1'b1, 1'b1, 6'h02, 128'h11, 1'b0);
        step(); drive(1'b0, 1'b0, 6'h00, 128'h0, 1'b1);
        step(); idle();
        step(); drive(1'b1, 1'b1, 6'h02, 128'h22, 1'b0);
        look();
        chk("both_credit_out", 0, FW'(o_credit[0]), 128'd1);
        chk("both_count_pre",  0, FW'(o_cnt[0]), 128'd1);
        step(); idle();
        look();
        chk("both_count_post", 0, FW'(o_cnt[0]), 128'd1);
        chk("both_no_uf",      0, FW'(o_uf[0]), 128'd0);
        chk("both_no_of",      0, FW'(o_of[0]), 128'd0);

        // Directed: 4-flit packet whose third flit changes destination
        reset_link();
        step(); drive(1'b1, 1'b0, 6'h05, 128'h41, 1'b0);
        look(); chk("pkt_inpkt_head",  0, FW'(o_inpk[0]), 128'd0);
        step(); drive(1'b1, 1'b0, 6'h05, 128'h42, 1'b0);
        look(); chk("pkt_inpkt_body",  0, FW'(o_inpk[0]), 128'd1);
        step(); drive(1'b1, 1'b0, 6'h06, 128'h43, 1'b0);
        look(); chk("pkt_dc_not_yet",  0, FW'(o_dc[0]), 128'd0);
        step(); drive(1'b1, 1'b1, 6'h05, 128'h44, 1'b0);
        look();
        chk("pkt_dc_set",      0, FW'(o_dc[0]), 128'd1);
        chk("pkt_inpkt_tail",  0, FW'(o_inpk[0]), 128'd1);
        step(); idle();
        look();
        chk("pkt_inpkt_after", 0, FW'(o_inpk[0]), 128'd0);
        chk("pkt_dc_sticky",   0, FW'(o_dc[0]), 128'd1);

        // Directed: credit returned while count is already full
        reset_link();
        step(); drive(1'b0, 1'b0, 6'h00, 128'h0, 1'b1);
        look();
        chk("of_p0_credit_out", 1, FW'(o_credit[1]), 128'd1);
        chk("of_p0_not_yet",    1, FW'(o_of[1]), 128'd0);
        step(); idle();
        look();
        chk("of_p0_set",   1, FW'(o_of[1]), 128'd1);
        chk("of_p0_count", 1, FW'(o_cnt[1]), 128'd2);
        chk("of_p2_early", 0, FW'(o_of[0]), 128'd0);
        step();
        look();
        chk("of_p2_credit_out", 0, FW'(o_credit[0]), 128'd1);
        step();
        look();
        chk("of_p2_set",   0, FW'(o_of[0]), 128'd1);
        chk("of_p2_count", 0, FW'(o_cnt[0]), 128'd2);

        // Directed: reset with two flits inside the pipeline
        reset_link();
        step(); drive(1'b1, 1'b0, 6'h03, 128'h31, 1'b0);
        step(); drive(1'b1, 1'b1, 6'h03, 128'h32, 1'b0);
        step(); rst_n = 1'b0; idle();
        look();
        chk("rst_mid_send",  0, FW'(o_send[0]), 128'd0);
        chk("rst_mid_count", 0, FW'(o_cnt[0]), 128'd2);
        step(); step(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look();
            chk("rst_no_emerge", 0, FW'(o_send[0]), 128'd0);
            chk("rst_count_rel", 0, FW'(o_cnt[0]), 128'd2);
            step();
        end

        // Directed: three packets, seven flits
        reset_link();
        for (int p = 0; p < 3; p++) begin
            for (int f = 0; f < plen[p]; f++) begin
                step(); drive(1'b1, (f == plen[p] - 1), DW'(p), FW'(p * 16 + f), 1'b1);
            end
        end
        step(); idle();
        for (int i = 0; i < 4; i++) step();
        look();
`ifdef NOC_LINK_STATS_EN
        chk("stats_flits", 0, FW'(o_fc[0]), 128'd7);
        chk("stats_pkts",  0, FW'(o_pc[0]), 128'd3);
        chk("stats_flits", 1, FW'(o_fc[1]), 128'd7);
        chk("stats_pkts",  1, FW'(o_pc[1]), 128'd3);
`else
        chk("stats_flits_off", 0, FW'(o_fc[0]), 128'd0);
        chk("stats_pkts_off",  0, FW'(o_pc[0]), 128'd0);
`endif

        // Randomized traffic, several reset epochs with different rates
        for (int seg = 0; seg < 6; seg++) begin
            reset_link();
            ps  = $urandom_range(10, 80);
            pcr = $urandom_range(10, 80);
            for (int c = 0; c < 300; c++) begin
                step();
                drive($urandom_range(0, 99) < ps,
                      $urandom_range(0, 3) == 0,
                      ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 63)) : 6'h2A,
                      {$urandom, $urandom, $urandom, $urandom},
                      $urandom_range(0, 99) < pcr);
            end
        end

        step(); idle();
        step();
        look();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
